// File: rtl/ldpc_decode_top.sv
// LDPC frame loader and hard-decision stage: buffers one frame of LLR columns,
// then streams the sign bits of the 21 information columns downstream.
module ldpc_decode_top #(
   parameter int ZC     = 512,
   parameter int VWIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           mode,
   output logic                 W_READY,
   input  logic                 W_VALID,
   input  logic                 W_LAST,
   input  logic [ZC*VWIDTH-1:0] W_DATA,
   input  logic                 R_READY,
   output logic                 R_VALID,
   output logic                 R_LAST,
   output logic [ZC*VWIDTH-1:0] R_DATA,
   output logic [1:0]           dbg_state_o
);
   // Handshake: a beat moves on a rising edge where VALID and READY are both 1;
   // R_VALID/R_LAST/R_DATA hold stable while R_VALID=1 and R_READY is not 1.
   localparam int         DW            = ZC * VWIDTH;
   localparam logic [4:0] LAST_COL_R23  = 5'd31;
   localparam logic [4:0] LAST_COL_R78  = 5'd23;
   localparam logic [4:0] LAST_INFO_COL = 5'd20;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_DECODE = 2'd1,
      ST_OUTPUT = 2'd2
   } state_t;

   state_t        state_q;
   logic [4:0]    w_idx_q;
   logic [4:0]    r_idx_q;
   logic          rate78_q;
   logic          w_ready_q;
   logic          r_valid_q;
   logic          r_last_q;
   logic [ZC-1:0] r_data_q;
   logic [31:0]   col_valid_q;
   logic [ZC-1:0] sign_mem_q [32];

   logic [ZC-1:0] w_sign;
   logic          wr_fire;
   logic          rd_fire;
   logic          rate78_eff;
   logic          frame_end;
   logic [4:0]    rd_col_idx;
   logic [ZC-1:0] rd_col;
   logic          unused_llr_mag;

   // Only the hard decision is ever emitted, so only each lane's sign bit is kept.
   always_comb begin
      w_sign = '0;
      for (int i = 0; i < ZC; i++) begin
         w_sign[i] = W_DATA[VWIDTH*i + VWIDTH - 1];
      end
   end
   assign unused_llr_mag = ^W_DATA;

   assign wr_fire    = (state_q == ST_LOAD) && w_ready_q && W_VALID;
   assign rd_fire    = (state_q == ST_OUTPUT) && r_valid_q && R_READY;
   assign rate78_eff = (w_idx_q == 5'd0) ? (mode == 2'd2) : rate78_q;
   assign frame_end  = W_LAST || (w_idx_q == (rate78_eff ? LAST_COL_R78 : LAST_COL_R23));

   // Column presented on the next beat; unwritten columns read as zero LLRs.
   assign rd_col_idx = (state_q == ST_OUTPUT) ? (r_idx_q + 5'd1) : 5'd0;
   assign rd_col     = col_valid_q[rd_col_idx] ? sign_mem_q[rd_col_idx] : '0;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         sign_mem_q[w_idx_q] <= w_sign;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         w_idx_q     <= 5'd0;
         r_idx_q     <= 5'd0;
         rate78_q    <= 1'b0;
         w_ready_q   <= 1'b0;
         r_valid_q   <= 1'b0;
         r_last_q    <= 1'b0;
         r_data_q    <= '0;
         col_valid_q <= '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               w_ready_q <= 1'b1;
               if (wr_fire) begin
                  col_valid_q[w_idx_q] <= 1'b1;
                  if (w_idx_q == 5'd0) begin
                     rate78_q <= (mode == 2'd2);
                  end
                  if (frame_end) begin
                     state_q   <= ST_DECODE;
                     w_ready_q <= 1'b0;
                     w_idx_q   <= 5'd0;
                  end else begin
                     w_idx_q <= w_idx_q + 5'd1;
                  end
               end
            end
            ST_DECODE: begin
               state_q   <= ST_OUTPUT;
               r_idx_q   <= 5'd0;
               r_valid_q <= 1'b1;
               r_last_q  <= 1'b0;
               r_data_q  <= rd_col;
            end
            ST_OUTPUT: begin
               if (rd_fire) begin
                  if (r_idx_q == LAST_INFO_COL) begin
                     // Dropping the valid mask is what clears the buffer for the next frame.
                     state_q     <= ST_LOAD;
                     w_ready_q   <= 1'b1;
                     r_valid_q   <= 1'b0;
                     r_last_q    <= 1'b0;
                     r_data_q    <= '0;
                     r_idx_q     <= 5'd0;
                     col_valid_q <= '0;
                  end else begin
                     r_idx_q  <= r_idx_q + 5'd1;
                     r_data_q <= rd_col;
                     r_last_q <= ((r_idx_q + 5'd1) == LAST_INFO_COL);
                  end
               end
            end
            default: begin
               state_q <= ST_LOAD;
            end
         endcase
      end
   end

   assign W_READY     = w_ready_q;
   assign R_VALID     = r_valid_q;
   assign R_LAST      = r_last_q;
   assign R_DATA      = DW'(r_data_q);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ldpc_decode_top.sv
// Bench for ldpc_decode_top: directed frames with random LLRs, checked against
// a frame-level model of the hard decisions of the first 21 accepted columns.
module tb_ldpc_decode_top;
   localparam int ZC = 512;
   localparam int VW = 6;
   localparam int DW = ZC * VW;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic [1:0]    mode    = 2'd0;
   logic          W_READY;
   logic          W_VALID = 1'b0;
   logic          W_LAST  = 1'b0;
   logic [DW-1:0] W_DATA  = '0;
   logic          R_READY = 1'b0;
   logic          R_VALID;
   logic          R_LAST;
   logic [DW-1:0] R_DATA;
   logic [1:0]    dbg_state;

   int            checks   = 0;
   int            failures = 0;
   int            frame_llr [32][ZC];
   logic [DW-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   ldpc_decode_top #(.ZC(ZC), .VWIDTH(VW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode        (mode),
      .W_READY     (W_READY),
      .W_VALID     (W_VALID),
      .W_LAST      (W_LAST),
      .W_DATA      (W_DATA),
      .R_READY     (R_READY),
      .R_VALID     (R_VALID),
      .R_LAST      (R_LAST),
      .R_DATA      (R_DATA),
      .dbg_state_o (dbg_state)
   );

   // ---------------- comparison helpers ----------------
   task automatic check_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      int j;
      int base;
      checks++;
      assert (obs === exp) else begin
         failures++;
         j = 0;
         for (int b = DW - 1; b >= 0; b--) if (obs[b] !== exp[b]) j = b;
         base = (j / 64) * 64;
         if (base > DW - 64) base = DW - 64;
         $error("FAIL %s: first diff bit %0d, bits[%0d+:64] observed=%h expected=%h",
                tag, j, base, obs[base +: 64], exp[base +: 64]);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic fill_frame(input int kind);
      for (int k = 0; k < 32; k++) begin
         for (int i = 0; i < ZC; i++) begin
            case (kind)
               1:       frame_llr[k][i] = (k % 2 == 1) ? -1 : 1;
               2:       frame_llr[k][i] = (i % 2 == 0) ? -32 : 0;
               default: frame_llr[k][i] = int'($urandom_range(63)) - 32;
            endcase
         end
      end
   endtask

   // Output beat k is the hard decision of column k if it was accepted, else all zero.
   task automatic push_expected(input int n_written);
      logic [DW-1:0] e;
      for (int k = 0; k < 21; k++) begin
         e = '0;
         if (k < n_written) begin
            for (int i = 0; i < ZC; i++) e[i] = (frame_llr[k][i] < 0);
         end
         exp_q.push_back(e);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic write_frame(input logic [1:0] first_mode, input int last_at);
      int n_cols;
      int n_beats;
      int wait_cyc;
      logic [DW-1:0] d;
      n_cols  = (first_mode == 2'd2) ? 24 : 32;
      n_beats = (last_at < n_cols) ? last_at + 1 : n_cols;
      for (int b = 0; b < n_beats; b++) begin
         @(posedge clk); #1;
         for (int i = 0; i < ZC; i++) d[VW*i +: VW] = VW'(frame_llr[b][i]);
         W_DATA  = d;
         W_VALID = 1'b1;
         W_LAST  = (b == last_at);
         mode    = (b == 0) ? first_mode : 2'($urandom_range(3));
         @(negedge clk);
         wait_cyc = 0;
         while (W_READY !== 1'b1 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
         end
         check_bit("w_ready_beat", W_READY, 1'b1);
      end
      push_expected(n_beats);
      @(posedge clk); #1;
      W_VALID = 1'b0;
      W_LAST  = 1'b0;
      @(negedge clk);
      check_bit("w_ready_drop", W_READY, 1'b0);
      check_bit("decode_rvalid", R_VALID, 1'b0);
      @(negedge clk);
      check_bit("rvalid_latency", R_VALID, 1'b1);
      check_bit("w_ready_output", W_READY, 1'b0);
   endtask

   // pat: 0 = always ready, 1 = toggle, 2 = random 0/1/X
   task automatic read_frame(input int pat, input int n_beats, input bit junk);
      int beat = 0;
      int cyc  = 0;
      int r;
      bit stalled = 0;
      logic [DW-1:0] held_data;
      logic held_last;
      logic [DW-1:0] e;
      while (beat < n_beats && cyc < 400) begin
         @(posedge clk); #1;
         case (pat)
            1: R_READY = (cyc % 2 == 0);
            2: begin
               r = $urandom_range(2);
               R_READY = (r == 0) ? 1'b0 : ((r == 1) ? 1'b1 : 1'bx);
            end
            default: R_READY = 1'b1;
         endcase
         if (junk) begin
            W_VALID = 1'($urandom_range(1));
            W_LAST  = 1'($urandom_range(1));
            W_DATA  = {(DW / 32){$urandom()}};
         end
         @(negedge clk);
         cyc++;
         if (stalled) begin
            check_bit("stall_valid", R_VALID, 1'b1);
            check_bit("stall_last", R_LAST, held_last);
            check_vec("stall_data", R_DATA, held_data);
         end
         stalled = 0;
         check_bit("w_ready_busy", W_READY, 1'b0);
         check_bit("rvalid_output", R_VALID, 1'b1);
         if (R_VALID === 1'b1 && R_READY === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check_vec("beat_data", R_DATA, e);
            check_bit("beat_last", R_LAST, (beat == 20));
            beat++;
         end else if (R_VALID === 1'b1) begin
            stalled   = 1;
            held_data = R_DATA;
            held_last = R_LAST;
         end
      end
      check_int("read_count", beat, n_beats);
      if (n_beats == 21) begin
         @(posedge clk); #1;
         R_READY = 1'b0;
         W_VALID = 1'b0;
         W_LAST  = 1'b0;
         @(negedge clk);
         check_bit("w_ready_back", W_READY, 1'b1);
         check_bit("rvalid_idle", R_VALID, 1'b0);
         check_bit("rlast_idle", R_LAST, 1'b0);
         check_vec("rdata_idle", R_DATA, '0);
      end
      W_VALID = 1'b0;
      W_LAST  = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int rm;
      int rl;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_bit("reset_wready", W_READY, 1'b0);
      check_bit("reset_rvalid", R_VALID, 1'b0);
      check_bit("reset_rlast", R_LAST, 1'b0);
      check_vec("reset_rdata", R_DATA, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_bit("wready_before_edge", W_READY, 1'b0);
      @(negedge clk);
      check_bit("wready_after_reset", W_READY, 1'b1);

      // alternating +1/-1 columns, rate 2/3, W_LAST on the final beat
      fill_frame(1);
      write_frame(2'd1, 31);
      read_frame(0, 21, 0);

      // rate 7/8 ends on the 24th beat without W_LAST
      fill_frame(2);
      write_frame(2'd2, 99);
      read_frame(0, 21, 0);

      fill_frame(0);
      write_frame(2'd1, 99);
      read_frame(1, 21, 0);

      // early W_LAST: columns 10..20 must not show the previous frame
      fill_frame(0);
      write_frame(2'd1, 9);
      read_frame(2, 21, 1);

      fill_frame(0);
      write_frame(2'd0, 99);
      read_frame(2, 21, 1);

      fill_frame(0);
      write_frame(2'd3, 20);
      read_frame(1, 21, 0);

      // reset while beat 5 is presented
      fill_frame(0);
      write_frame(2'd2, 99);
      read_frame(0, 5, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_bit("midreset_rvalid", R_VALID, 1'b0);
      check_bit("midreset_wready", W_READY, 1'b0);
      check_vec("midreset_rdata", R_DATA, '0);
      @(negedge clk);
      check_bit("midreset_wready_up", W_READY, 1'b1);
      R_READY = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_bit("midreset_no_beats", R_VALID, 1'b0);
      end
      R_READY = 1'b0;
      exp_q.delete();

      fill_frame(0);
      write_frame(2'd2, 23);
      read_frame(2, 21, 0);

      for (int f = 0; f < 3; f++) begin
         rm = $urandom_range(3);
         rl = $urandom_range(40);
         fill_frame(0);
         write_frame(2'(rm), rl);
         read_frame(2, 21, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
